// File: rtl/mul32_pkg.sv
// Shared types and constants for the mul32 sequencer and its shift-add core.
package mul32_pkg;

  localparam int MUL32_OP_W   = 32;
  localparam int MUL32_PROD_W = 64;
  localparam int MUL32_LAT    = 35;
  localparam int MUL32_STEPS  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mul32_seq_state_t;

endpackage

// File: rtl/mul32_sign_fix.sv
// Combinational helpers: operand magnitudes, negate flag and 64-bit product negation.
module mul32_sign_fix
  import mul32_pkg::*;
(
  input  logic                    op_signed,
  input  logic [MUL32_OP_W-1:0]   a,
  input  logic [MUL32_OP_W-1:0]   b,
  input  logic [MUL32_PROD_W-1:0] raw_product,
  input  logic                    neg_sel,
  output logic [MUL32_OP_W-1:0]   mag_a,
  output logic [MUL32_OP_W-1:0]   mag_b,
  output logic                    neg,
  output logic [MUL32_PROD_W-1:0] fixed_product
);

  // 0x8000_0000 negates to itself, which is the correct unsigned magnitude.
  assign mag_a = (op_signed & a[MUL32_OP_W-1]) ? (~a + 32'd1) : a;
  assign mag_b = (op_signed & b[MUL32_OP_W-1]) ? (~b + 32'd1) : b;
  assign neg   = op_signed & (a[MUL32_OP_W-1] ^ b[MUL32_OP_W-1]);

  assign fixed_product = neg_sel ? (~raw_product + 64'd1) : raw_product;

endmodule

// File: rtl/mul32_slow.sv
// 32-step shift-add unsigned multiplier core with level-sensitive start and sticky finish.
module mul32_slow
  import mul32_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MUL32_OP_W-1:0]   multiplicand,
  input  logic [MUL32_OP_W-1:0]   multiplier,
  output logic [MUL32_PROD_W-1:0] product,
  output logic                    finish
);

  logic                    running;
  logic [5:0]              cnt;
  logic [MUL32_PROD_W-1:0] acc;
  logic [MUL32_OP_W:0]     sum;

  // Upper half accumulates; lower half holds the remaining multiplier bits.
  always_comb begin
    sum = {1'b0, acc[MUL32_PROD_W-1:MUL32_OP_W]}
        + (acc[0] ? {1'b0, multiplicand} : {(MUL32_OP_W+1){1'b0}});
  end

  // One extra cycle after the last step raises finish, giving 33 edges from start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= 6'd0;
      acc     <= '0;
      finish  <= 1'b0;
    end else if (!running) begin
      if (start) begin
        running <= 1'b1;
        cnt     <= 6'd0;
        acc     <= {{MUL32_OP_W{1'b0}}, multiplier};
        finish  <= 1'b0;
      end
    end else if (cnt == 6'(MUL32_STEPS)) begin
      running <= 1'b0;
      finish  <= 1'b1;
    end else begin
      acc <= {sum, acc[MUL32_OP_W-1:1]};
      cnt <= cnt + 6'd1;
    end
  end

  assign product = acc;

endmodule

// File: rtl/mul32_seq.sv
// Issue/retire sequencer around mul32_slow with valid/ready on both sides.
// Signed operand support is compiled in only when MUL32_SEQ_SIGNED_EN is defined.
module mul32_seq
  import mul32_pkg::*;
#(
  parameter int TAG_W = 4
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MUL32_OP_W-1:0]   in_a,
  input  logic [MUL32_OP_W-1:0]   in_b,
  input  logic                    in_signed,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MUL32_PROD_W-1:0] out_product,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid, once raised, holds its payload stable until that edge.
  mul32_seq_state_t state, state_next;

  logic                    accept;
  logic                    core_start;
  logic                    core_finish;
  logic [MUL32_PROD_W-1:0] core_product;
  logic [MUL32_PROD_W-1:0] prod_fixed;
  logic [MUL32_OP_W-1:0]   mag_a_d, mag_b_d;
  logic [MUL32_OP_W-1:0]   mag_a_q, mag_b_q;
  logic                    neg_d, neg_q;
  logic [TAG_W-1:0]        tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    core_start = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = START;
      end
      START: begin
        core_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (core_finish) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

`ifdef MUL32_SEQ_SIGNED_EN
  mul32_sign_fix u_sign_fix (
    .op_signed     (in_signed),
    .a             (in_a),
    .b             (in_b),
    .raw_product   (core_product),
    .neg_sel       (neg_q),
    .mag_a         (mag_a_d),
    .mag_b         (mag_b_d),
    .neg           (neg_d),
    .fixed_product (prod_fixed)
  );
`else
  logic unused_sign;
  assign mag_a_d     = in_a;
  assign mag_b_d     = in_b;
  assign neg_d       = 1'b0;
  assign prod_fixed  = core_product;
  assign unused_sign = in_signed ^ neg_q;
`endif

  // Operand registers feed the core directly and stay frozen until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      neg_q       <= 1'b0;
      tag_q       <= '0;
      out_product <= '0;
      out_tag     <= '0;
    end else begin
      if (accept) begin
        mag_a_q <= mag_a_d;
        mag_b_q <= mag_b_d;
        neg_q   <= neg_d;
        tag_q   <= in_tag;
      end
      if (state == WAIT && core_finish) begin
        out_product <= prod_fixed;
        out_tag     <= tag_q;
      end
    end
  end

  mul32_slow u_core (
    .clk          (clk),
    .rst          (rst),
    .start        (core_start),
    .multiplicand (mag_a_q),
    .multiplier   (mag_b_q),
    .product      (core_product),
    .finish       (core_finish)
  );

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: vector table, randomized model checks and handshake corners.
module tb_mul32_seq;
  import mul32_pkg::*;

  localparam int TAG_W = 4;
  localparam int W     = MUL32_PROD_W + TAG_W;
`ifdef MUL32_SEQ_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_signed = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_product;
  logic [3:0]  out_tag;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_run = 0;
  logic [W-1:0] exp_q[$];
  int ret_cyc[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [3:0]  tag;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  mul32_seq #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_signed   (in_signed),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_tag     (out_tag),
    .busy        (busy)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint signed sa, sb;
    if (SGN && s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_result: got tag %0d product %h with nothing expected", out_tag, out_product);
      end else begin
        e = exp_q.pop_front();
        check("product", 80'(out_product), 80'(e[W-1:TAG_W]));
        check("tag", 80'(out_tag), 80'(e[TAG_W-1:0]));
      end
      ret_cyc.push_back(cyc);
    end
  end

  // Core start must be a single-cycle pulse every time it fires.
  always @(negedge clk) begin
    if (dut.core_start) start_run++;
    else if (start_run != 0) begin
      check("start_width", 80'(start_run), 80'(1));
      start_run = 0;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [3:0] tag, input logic [63:0] exp, input bit keep,
                       output int acc);
    int n;
    in_a = a; in_b = b; in_signed = s; in_tag = tag; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      timeout("issue");
      in_valid = 1'b0;
      acc = cyc;
      return;
    end
    @(posedge clk);
    exp_q.push_back({exp, tag});
    @(negedge clk);
    acc = cyc;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int acc, input bit chk_lat);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout("wait_valid");
    else if (chk_lat) check("latency", 80'(cyc - acc), 80'(MUL32_LAT));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) timeout("wait_idle");
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int acc;
    logic [31:0] ra, rb;
    logic rs;
    logic [63:0] bp_exp;

    vecs[0] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, s: 1'b0, tag: 4'd3, exp: 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{a: 32'hFFFF_FFFD, b: 32'd5, s: 1'b1, tag: 4'd4,
                exp: SGN ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1};
    vecs[2] = '{a: 32'h8000_0000, b: 32'h8000_0000, s: 1'b1, tag: 4'd5, exp: 64'h4000_0000_0000_0000};
    vecs[3] = '{a: 32'h0000_0000, b: 32'hDEAD_BEEF, s: 1'b1, tag: 4'd6, exp: 64'd0};
    vecs[4] = '{a: 32'h0000_0001, b: 32'hFFFF_FFFF, s: 1'b1, tag: 4'd7,
                exp: SGN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF};
    vecs[5] = '{a: 32'h7FFF_FFFF, b: 32'h7FFF_FFFF, s: 1'b1, tag: 4'd8, exp: 64'h3FFF_FFFF_0000_0001};
    vecs[6] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, s: 1'b1, tag: 4'd9,
                exp: SGN ? 64'd1 : 64'hFFFF_FFFE_0000_0001};
    vecs[7] = '{a: 32'h8000_0000, b: 32'h7FFF_FFFF, s: 1'b1, tag: 4'd10,
                exp: SGN ? 64'hC000_0000_8000_0000 : 64'h3FFF_FFFF_8000_0000};
    vecs[8] = '{a: 32'd12345, b: 32'd6789, s: 1'b0, tag: 4'd11, exp: 64'd83810205};
    vecs[9] = '{a: 32'hFFFF_FFFD, b: 32'd5, s: 1'b0, tag: 4'd12, exp: 64'h0000_0004_FFFF_FFF1};

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_state", 80'({in_ready, out_valid, busy, out_tag, out_product}),
          80'({1'b1, 1'b0, 1'b0, 4'd0, 64'd0}));
    check("reset_core_start", 80'(dut.core_start), 80'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 80'({in_ready, busy}), 80'({1'b1, 1'b0}));

    // Vector table
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].tag, vecs[i].exp, 1'b0, acc);
      check("busy_after_accept", 80'({busy, in_ready}), 80'({1'b1, 1'b0}));
      wait_valid(acc, 1'b1);
      wait_idle();
    end

    // Randomized against the model
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000 | $urandom_range(0, 3);
        1: ra = $urandom_range(0, 255);
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 2) : $urandom;
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rs, 4'($urandom_range(0, 15)), ref_mul(ra, rb, rs), 1'b0, acc);
      wait_valid(acc, 1'b1);
      wait_idle();
    end

    // Backpressure: result held 20 cycles while another request waits
    out_ready = 1'b0;
    bp_exp = ref_mul(32'd123456, 32'd789, 1'b0);
    issue(32'd123456, 32'd789, 1'b0, 4'd9, bp_exp, 1'b0, acc);
    wait_valid(acc, 1'b1);
    in_a = 32'd11; in_b = 32'd13; in_signed = 1'b0; in_tag = 4'd10; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold", 80'({out_valid, in_ready, out_tag, out_product}),
            80'({1'b1, 1'b0, 4'd9, bp_exp}));
    end
    exp_q.push_back({64'd143, 4'd10});
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_retire", 80'({in_ready, out_valid}), 80'({1'b1, 1'b0}));
    @(negedge clk);
    check("bp_next_accept", 80'({busy, in_ready}), 80'({1'b1, 1'b0}));
    in_valid = 1'b0;
    acc = cyc;
    wait_valid(acc, 1'b1);
    wait_idle();

    // Back-to-back with in_valid held high
    ret_cyc.delete();
    for (int k = 0; k < 4; k++) begin
      ra = $urandom;
      rb = $urandom;
      issue(ra, rb, 1'b0, 4'(k + 1), ref_mul(ra, rb, 1'b0), 1'b1, acc);
    end
    in_valid = 1'b0;
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    check("b2b_count", 80'(ret_cyc.size()), 80'(4));
    for (int k = 1; k < 4 && k < ret_cyc.size(); k++)
      check("b2b_spacing", 80'(ret_cyc[k] - ret_cyc[k-1]), 80'(37));
    wait_idle();

    // Reset 10 cycles into WAIT aborts with no output
    issue(32'd1000, 32'd1000, 1'b0, 4'd2, 64'd1000000, 1'b0, acc);
    repeat (11) @(negedge clk);
    check("pre_abort_busy", 80'({busy, out_valid}), 80'({1'b1, 1'b0}));
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_state", 80'({in_ready, out_valid, busy, out_tag, out_product}),
          80'({1'b1, 1'b0, 1'b0, 4'd0, 64'd0}));
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) check("abort_no_output", 80'(out_valid), 80'(0));
    end
    issue(32'd7, 32'd6, 1'b0, 4'd5, 64'd42, 1'b0, acc);
    wait_valid(acc, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    check("queue_empty", 80'(exp_q.size()), 80'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
